// File: rtl/vga_text_writer_if.sv
// Key-input handshake plus video-memory write port of the text writer.
// master = key source / memory side, slave = the writer itself.
interface vga_text_writer_if;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready;
  logic       wren;
  logic [7:0] w_ascii_addr_x;
  logic [7:0] w_ascii_addr_y;
  logic [7:0] w_ascii;
  logic       busy;

  modport master (
    output key_valid, key_ascii,
    input  key_ready, wren, w_ascii_addr_x, w_ascii_addr_y, w_ascii, busy
  );

  modport slave (
    input  key_valid, key_ascii,
    output key_ready, wren, w_ascii_addr_x, w_ascii_addr_y, w_ascii, busy
  );
endinterface

// File: rtl/vga_text_writer.sv
// Terminal-style write controller: turns a stream of ASCII keys into video-memory
// writes, tracking a cursor and clearing new lines (and the whole screen after reset).
module vga_text_writer #(
  parameter int         COLS       = 70,
  parameter int         ROWS       = 64,
  parameter logic [7:0] BLANK      = 8'h20,
  parameter bit         INIT_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  vga_text_writer_if.slave kbus
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;
  localparam state_t RESET_STATE = INIT_CLEAR ? CLR_ALL : IDLE;

  state_t        state_reg, state_next;
  logic [XW-1:0] cx_reg, cx_next, clr_x_reg, clr_x_next, ax_reg, ax_next;
  logic [YW-1:0] cy_reg, cy_next, clr_y_reg, clr_y_next, ay_reg, ay_next;
  logic [7:0]    char_reg, char_next, w_ascii_reg, w_ascii_next;
  logic          advance_reg, advance_next;
  logic          wren_reg, wren_next, key_ready_reg, key_ready_next;
  logic          busy_reg, busy_next;

  logic          transfer, is_print, is_newline, is_bs;
  logic [YW-1:0] cy_inc;

  assign transfer   = kbus.key_valid & key_ready_reg & (state_reg == IDLE);
  assign is_print   = (kbus.key_ascii >= 8'h20) && (kbus.key_ascii <= 8'h7E);
  assign is_newline = (kbus.key_ascii == 8'h0A) || (kbus.key_ascii == 8'h0D);
  assign is_bs      = (kbus.key_ascii == 8'h08);
  assign cy_inc     = (cy_reg == Y_LAST) ? '0 : cy_reg + Y_ONE;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= RESET_STATE;
    else       state_reg <= state_next;
  end

  // Next-state and cursor/counter logic
  always_comb begin
    state_next   = state_reg;
    cx_next      = cx_reg;
    cy_next      = cy_reg;
    clr_x_next   = clr_x_reg;
    clr_y_next   = clr_y_reg;
    char_next    = char_reg;
    advance_next = advance_reg;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          if (is_print) begin
            state_next   = WRITE;
            char_next    = kbus.key_ascii;
            advance_next = 1'b1;
          end else if (is_newline) begin
            cx_next    = '0;
            cy_next    = cy_inc;
            clr_x_next = '0;
            state_next = CLR_LINE;
          end else if (is_bs && (cx_reg != '0)) begin
            cx_next      = cx_reg - X_ONE;
            char_next    = BLANK;
            advance_next = 1'b0;
            state_next   = WRITE;
          end else if (is_bs && (cy_reg != '0)) begin
            cx_next      = X_LAST;
            cy_next      = cy_reg - Y_ONE;
            char_next    = BLANK;
            advance_next = 1'b0;
            state_next   = WRITE;
          end
        end
      end
      WRITE: begin
        state_next = IDLE;
        if (advance_reg) begin
          if (cx_reg == X_LAST) begin
            cx_next    = '0;
            cy_next    = cy_inc;
            clr_x_next = '0;
            state_next = CLR_LINE;
          end else begin
            cx_next = cx_reg + X_ONE;
          end
        end
      end
      CLR_LINE: begin
        if (clr_x_reg == X_LAST) state_next = IDLE;
        else                     clr_x_next = clr_x_reg + X_ONE;
      end
      CLR_ALL: begin
        // The first cycle after reset only primes the scan; (0,0) is written next.
        if (wren_reg) begin
          if (clr_x_reg == X_LAST) begin
            clr_x_next = '0;
            if (clr_y_reg == Y_LAST) begin
              state_next = IDLE;
              cx_next    = '0;
              cy_next    = '0;
            end else begin
              clr_y_next = clr_y_reg + Y_ONE;
            end
          end else begin
            clr_x_next = clr_x_reg + X_ONE;
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Output values, registered below so every port comes straight from a flop
  always_comb begin
    wren_next      = 1'b0;
    ax_next        = cx_next;
    ay_next        = cy_next;
    w_ascii_next   = BLANK;
    key_ready_next = (state_next == IDLE);
    busy_next      = (state_next == CLR_LINE) || (state_next == CLR_ALL);
    case (state_next)
      WRITE: begin
        wren_next    = 1'b1;
        w_ascii_next = char_next;
      end
      CLR_LINE: begin
        wren_next = 1'b1;
        ax_next   = clr_x_next;
      end
      CLR_ALL: begin
        wren_next = 1'b1;
        ax_next   = clr_x_next;
        ay_next   = clr_y_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx_reg        <= '0;
      cy_reg        <= '0;
      clr_x_reg     <= '0;
      clr_y_reg     <= '0;
      char_reg      <= BLANK;
      advance_reg   <= 1'b0;
      wren_reg      <= 1'b0;
      ax_reg        <= '0;
      ay_reg        <= '0;
      w_ascii_reg   <= BLANK;
      key_ready_reg <= 1'b0;
      busy_reg      <= INIT_CLEAR;
    end else begin
      cx_reg        <= cx_next;
      cy_reg        <= cy_next;
      clr_x_reg     <= clr_x_next;
      clr_y_reg     <= clr_y_next;
      char_reg      <= char_next;
      advance_reg   <= advance_next;
      wren_reg      <= wren_next;
      ax_reg        <= ax_next;
      ay_reg        <= ay_next;
      w_ascii_reg   <= w_ascii_next;
      key_ready_reg <= key_ready_next;
      busy_reg      <= busy_next;
    end
  end

  assign kbus.wren           = wren_reg;
  assign kbus.w_ascii_addr_x = 8'(ax_reg);
  assign kbus.w_ascii_addr_y = 8'(ay_reg);
  assign kbus.w_ascii        = w_ascii_reg;
  assign kbus.key_ready      = key_ready_reg;
  assign kbus.busy           = busy_reg;
endmodule
